dec_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer, successor to the fixed 2-to-4 decoder. In direct mode it decodes the external select `I`. In scan mode it steps an internal index through all 2^N outputs at a programmable rate, for display digit multiplexing and row or channel strobing. It sits between the control logic and the output strobes. All outputs are registered, so the strobes are glitch-free.

---
 rtl/dec_scan.sv | 106 ++++++++++
 tb/tb_dec_scan.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot strobe decoder with a built-in scan sequencer.
// Direct mode decodes I; scan mode walks sel through every output at PRESCALE cycles per step.

module dec_scan_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hit,
  output logic z
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z <= 1'b0;
    else        z <= en & hit;
  end
endmodule

module dec_scan #(
  parameter int N        = 2,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic [N-1:0]      I,
  output logic [(1<<N)-1:0] Z,
  output logic [N-1:0]      sel,
  output logic              frame
);
  localparam int            OUTS    = 1 << N;
  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  SEL_MAX = N'(OUTS - 1);

  typedef enum logic [2:0] {
    OP_HOLD, OP_DIRECT, OP_ENTRY, OP_COUNT, OP_STEP
  } op_e;

  op_e           op;
  logic [PW-1:0] pre, pre_d;
  logic [N-1:0]  sel_d;
  logic          mode_q, mode_q_d, frame_d;

  always_comb begin
    op = OP_HOLD;
    if (enable) begin
      if (!mode)             op = OP_DIRECT;
      else if (!mode_q)      op = OP_ENTRY;
      else if (pre != PRE_MAX) op = OP_COUNT;
      else                   op = OP_STEP;
    end
  end

  always_comb begin
    sel_d    = sel;
    pre_d    = pre;
    mode_q_d = mode_q;
    frame_d  = 1'b0;
    unique case (op)
      OP_HOLD:   ;
      OP_DIRECT: begin
        sel_d    = I;
        pre_d    = '0;
        mode_q_d = 1'b0;
      end
      OP_ENTRY: begin
        sel_d    = '0;
        pre_d    = '0;
        mode_q_d = 1'b1;
      end
      OP_COUNT:  pre_d = pre + PW'(1);
      OP_STEP: begin
        pre_d   = '0;
        sel_d   = sel + N'(1);
        frame_d = (sel == SEL_MAX);
      end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      pre    <= '0;
      mode_q <= 1'b0;
      frame  <= 1'b0;
    end else begin
      sel    <= sel_d;
      pre    <= pre_d;
      mode_q <= mode_q_d;
      frame  <= frame_d;
    end
  end

  // Each strobe re-derives from sel_d every enabled cycle (not a literal hold),
  // so a scan resumed after a freeze lights its index again immediately.
  for (genvar k = 0; k < OUTS; k++) begin : g_lane
    dec_scan_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (enable),
      .hit  (sel_d == N'(k)),
      .z    (Z[k])
    );
  end
endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: drivers queue expected outputs, monitors pop and compare.

module tb_dec_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en0, mode0, en1, mode1;
  logic [1:0] i0;
  logic [2:0] i1;
  logic [3:0] z0;
  logic [1:0] s0;
  logic       f0;
  logic [7:0] z1;
  logic [2:0] s1;
  logic       f1;

  dec_scan #(.N(2), .PRESCALE(4)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .mode(mode0), .I(i0),
    .Z(z0), .sel(s0), .frame(f0)
  );

  dec_scan #(.N(3), .PRESCALE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .mode(mode1), .I(i1),
    .Z(z1), .sel(s1), .frame(f1)
  );

  typedef struct {
    int         tag;
    logic [7:0] z;
    logic [2:0] sel;
    logic       frame;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   tag    = 0;

  task automatic chk(input string nm, input int t, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h want %0h", nm, t, got, want);
    end
  endtask

  // u0 is also sampled right after an asynchronous reset assertion
  always begin : mon0
    exp_t e;
    @(posedge clk or negedge rst_n);
    #1;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("u0.Z",     e.tag, {4'b0, z0}, e.z);
      chk("u0.sel",   e.tag, {6'b0, s0}, {5'b0, e.sel});
      chk("u0.frame", e.tag, {7'b0, f0}, {7'b0, e.frame});
    end
  end

  always begin : mon1
    exp_t e;
    @(posedge clk);
    #1;
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("u1.Z",     e.tag, z1, e.z);
      chk("u1.sel",   e.tag, {5'b0, s1}, {5'b0, e.sel});
      chk("u1.frame", e.tag, {7'b0, f1}, {7'b0, e.frame});
    end
  end

  task automatic d0(input logic en, input logic md, input logic [1:0] i,
                    input logic [3:0] z, input logic [1:0] s, input logic f);
    @(negedge clk);
    en0 = en; mode0 = md; i0 = i;
    tag++;
    q0.push_back('{tag, {4'b0, z}, {1'b0, s}, f});
  endtask

  task automatic d1(input logic en, input logic md, input logic [2:0] i,
                    input logic [7:0] z, input logic [2:0] s, input logic f);
    @(negedge clk);
    en1 = en; mode1 = md; i1 = i;
    tag++;
    q1.push_back('{tag, z, s, f});
  endtask

  logic [3:0] dir_z [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] scan_z[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0; mode0 = 1'b0; i0 = '0;
    en1 = 1'b0; mode1 = 1'b0; i1 = '0;
    q0.push_back('{0, 8'h00, 3'd0, 1'b0});
    q1.push_back('{0, 8'h00, 3'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // direct decode
    for (int i = 0; i < 4; i++) d0(1'b1, 1'b0, 2'(i), dir_z[i], 2'(i), 1'b0);

    // disabled in both modes: strobes off, sel frozen at 3
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++) d0(1'b0, 1'(m), 2'(i), 4'b0000, 2'd3, 1'b0);

    // scan entry, full period, wrap, then into second cycle of index 2
    for (int c = 0; c < 26; c++)
      d0(1'b1, 1'b1, 2'(c * 3), scan_z[(c % 16) / 4], 2'((c % 16) / 4), c == 16);

    // freeze for 5 cycles, then finish index 2 and move to 3
    for (int c = 0; c < 5; c++) d0(1'b0, 1'b1, 2'd1, 4'b0000, 2'd2, 1'b0);
    d0(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0);
    d0(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0);
    d0(1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b0);
    d0(1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b0);

    // asynchronous reset between edges while sel=3
    @(negedge clk);
    tag++;
    q0.push_back('{tag, 8'h00, 3'd0, 1'b0});
    #2 rst_n = 1'b0;
    #2 tag++;
    q0.push_back('{tag, 8'h00, 3'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    tag++;
    q0.push_back('{tag, 8'h01, 3'd0, 1'b0});
    for (int c = 0; c < 3; c++) d0(1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b0);
    d0(1'b1, 1'b1, 2'd3, 4'b0010, 2'd1, 1'b0);

    // back to direct, then scan restarts at index 0
    d0(1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0);
    d0(1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b0);
    d0(1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b0);
    d0(1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0);

    // N=3, PRESCALE=1: one index per cycle, frame every 8
    for (int c = 0; c < 17; c++)
      d1(1'b1, 1'b1, 3'(c * 5), 8'(1 << (c % 8)), 3'(c % 8), (c == 8) || (c == 16));

    repeat (3) @(negedge clk);
    chk("drain", 0, 8'(q0.size() + q1.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at time %0t", $time);
    $fatal(1);
  end
endmodule
